mux_scan_sel: RTL and testbench

- Parametrised, registered successor to the TTL 8:1 data selector.
- Selects one of CHANNELS input words of WIDTH bits each and presents true and complement outputs one clock after sampling.
- Adds an auto-scan mode that snapshots all inputs and streams them out one channel per enabled cycle, starting from a chosen channel with wrap-around.
- Used for serialising status/condition buses and for diagnostic bus scanning.

---
 rtl/mux_scan_sel_if.sv | 30 +++
 rtl/mux_scan_sel.sv | 147 ++++++++++++++
 tb/tb_mux_scan_sel.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: channel data and control in, selected word
// plus scan status out. The master side drives data/control; the selector
// is the slave.
interface mux_scan_sel_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SELW     = 3
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SELW-1:0]           sel;
  logic                      ce_n;
  logic                      mode;
  logic                      start;
  logic [WIDTH-1:0]          q;
  logic [WIDTH-1:0]          q_n;
  logic                      valid;
  logic [SELW-1:0]           chan;
  logic                      busy;
  logic                      done;

  modport master (
    output din, sel, ce_n, mode, start,
    input  q, q_n, valid, chan, busy, done
  );

  modport slave (
    input  din, sel, ce_n, mode, start,
    output q, q_n, valid, chan, busy, done
  );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered CHANNELS:1 data selector with true/complement outputs and an
// auto-scan mode that snapshots all channels and streams them out one per
// enabled cycle, starting at a chosen channel and wrapping around.
module mux_scan_sel #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SELW     = 3
) (
  input  logic            clk,
  input  logic            reset,
  mux_scan_sel_if.slave   bus
);

  localparam int              NSLOT    = 1 << SELW;
  localparam int              CNTW     = $clog2(CHANNELS + 1);
  localparam logic [SELW:0]   CH_EXT   = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CHANNELS - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                    state_q, state_d;
  logic [SELW-1:0]           idx_q, idx_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0]          q_q, q_d;
  logic [WIDTH-1:0]          q_n_q, q_n_d;
  logic                      valid_q, valid_d;
  logic [SELW-1:0]           chan_q, chan_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Channel views of live and snapshot data, padded to a full power-of-two
  // table so any select value indexes a defined (zero) slot.
  logic [WIDTH-1:0] din_ch  [NSLOT];
  logic [WIDTH-1:0] snap_ch [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < CHANNELS) begin : g_used
      assign din_ch[k]  = bus.din[k*WIDTH +: WIDTH];
      assign snap_ch[k] = snap_q[k*WIDTH +: WIDTH];
    end else begin : g_unused
      assign din_ch[k]  = '0;
      assign snap_ch[k] = '0;
    end
  end

  logic sel_ok;
  assign sel_ok = ({1'b0, bus.sel} < CH_EXT);

  // Next-state and next-output decode for direct selection and scanning.
  always_comb begin
    // NOTE: every target gets a default up front so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    q_d     = q_q;
    chan_d  = chan_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.mode && bus.start) begin
          // Accept a scan: freeze all channels and pick the start index.
          snap_d  = bus.din;
          idx_d   = sel_ok ? bus.sel : '0;
          chan_d  = sel_ok ? bus.sel : '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          q_d     = '0;
          state_d = ST_SCAN;
        end else begin
          chan_d = bus.sel;
          if (!bus.ce_n && sel_ok) begin
            q_d     = din_ch[bus.sel];
            valid_d = 1'b1;
          end else begin
            q_d = '0;
          end
        end
      end

      ST_SCAN: begin
        // A high ce_n pauses: q/chan/idx/count hold, valid drops.
        if (!bus.ce_n) begin
          q_d     = snap_ch[idx_q];
          chan_d  = idx_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Final word goes out with done; busy falls on the next IDLE edge.
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    q_n_d = ~q_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the snapshot is a plain register, cleared so a scan never
      // exposes stale data from before reset.
      snap_q  <= '0;
      q_q     <= '0;
      q_n_q   <= '1;
      valid_q <= 1'b0;
      chan_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      q_q     <= q_d;
      q_n_q   <= q_n_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.q_n   = q_n_q;
  assign bus.valid = valid_q;
  assign bus.chan  = chan_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel: the stimulus process queues the output
// expected on the next cycle; a negedge monitor pops and compares.
// Instance A: WIDTH=4, CHANNELS=8. Instance B: WIDTH=1, CHANNELS=6.
module tb_mux_scan_sel;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_scan_sel_if #(.WIDTH(4), .CHANNELS(8), .SELW(3)) ifa ();
  mux_scan_sel_if #(.WIDTH(1), .CHANNELS(6), .SELW(3)) ifb ();

  mux_scan_sel #(.WIDTH(4), .CHANNELS(8), .SELW(3)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  mux_scan_sel #(.WIDTH(1), .CHANNELS(6), .SELW(3)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic       valid;
    logic [2:0] chan;
    logic       chk_chan;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   words_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] q, input logic v, input logic [2:0] ch,
                        input logic cc, input logic b, input logic d, input string tag);
    exp_t e;
    e.cyc = cyc + 1; e.q = q; e.valid = v; e.chan = ch; e.chk_chan = cc;
    e.busy = b; e.done = d; e.tag = tag;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic q, input logic v, input logic [2:0] ch,
                        input logic cc, input logic b, input logic d, input string tag);
    exp_t e;
    e.cyc = cyc + 1; e.q = {3'b000, q}; e.valid = v; e.chan = ch; e.chk_chan = cc;
    e.busy = b; e.done = d; e.tag = tag;
    qb.push_back(e);
  endtask

  // Monitor: compare every queued expectation on the cycle it belongs to.
  always @(negedge clk) begin
    if (ifa.valid === 1'b1) words_a++;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      ea = qa.pop_front();
      checks++;
      if (ea.cyc != cyc) begin
        errors++;
        $display("FAIL %s(A): expectation for cycle %0d reached monitor at cycle %0d",
                 ea.tag, ea.cyc, cyc);
      end else if (ifa.q !== ea.q || ifa.q_n !== ~ea.q || ifa.valid !== ea.valid ||
                   (ea.chk_chan && ifa.chan !== ea.chan) ||
                   ifa.busy !== ea.busy || ifa.done !== ea.done) begin
        errors++;
        $display("FAIL %s(A) cyc=%0d: got q=%h q_n=%h valid=%b chan=%0d busy=%b done=%b; want q=%h q_n=%h valid=%b chan=%0d busy=%b done=%b",
                 ea.tag, cyc, ifa.q, ifa.q_n, ifa.valid, ifa.chan, ifa.busy, ifa.done,
                 ea.q, ~ea.q, ea.valid, ea.chan, ea.busy, ea.done);
      end
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      eb = qb.pop_front();
      checks++;
      if (eb.cyc != cyc) begin
        errors++;
        $display("FAIL %s(B): expectation for cycle %0d reached monitor at cycle %0d",
                 eb.tag, eb.cyc, cyc);
      end else if (ifb.q !== eb.q[0] || ifb.q_n !== ~eb.q[0] || ifb.valid !== eb.valid ||
                   (eb.chk_chan && ifb.chan !== eb.chan) ||
                   ifb.busy !== eb.busy || ifb.done !== eb.done) begin
        errors++;
        $display("FAIL %s(B) cyc=%0d: got q=%b q_n=%b valid=%b chan=%0d busy=%b done=%b; want q=%b q_n=%b valid=%b chan=%0d busy=%b done=%b",
                 eb.tag, cyc, ifb.q, ifb.q_n, ifb.valid, ifb.chan, ifb.busy, ifb.done,
                 eb.q[0], ~eb.q[0], eb.valid, eb.chan, eb.busy, eb.done);
      end
    end
  end

  // Hand-computed expectations.
  logic [3:0] dir_exp  [8] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
  logic [3:0] scan5    [8] = '{4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] scan2    [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
  logic [2:0] scanb_ch [6] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic       scanb_q  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset     = 1'b1;
    ifa.din   = '0; ifa.sel = '0; ifa.ce_n = 1'b1; ifa.mode = 1'b0; ifa.start = 1'b0;
    ifb.din   = '0; ifb.sel = '0; ifb.ce_n = 1'b1; ifb.mode = 1'b0; ifb.start = 1'b0;

    // Reset values on both instances.
    for (int i = 0; i < 2; i++) begin
      push_a(4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "reset");
      push_b(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "reset");
      tick();
    end
    reset = 1'b0;

    // Direct sweep: channel k nibble = bit k of 8'b1010_0110.
    ifa.din  = 32'h1010_0110;
    ifa.ce_n = 1'b0;
    for (int s = 0; s < 8; s++) begin
      ifa.sel = 3'(s);
      push_a(dir_exp[s], 1'b1, 3'(s), 1'b1, 1'b0, 1'b0, "direct");
      tick();
    end

    // Strobe off forces zero.
    ifa.ce_n = 1'b1;
    ifa.sel  = 3'd2;
    push_a(4'h0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, "strobe");
    tick();

    // Six-channel instance: out-of-range select and in-range selects.
    ifb.din  = 6'b10_0110;
    ifb.ce_n = 1'b0;
    ifb.sel  = 3'd7;
    push_b(1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, "range");
    tick();
    ifb.sel = 3'd5;
    push_b(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, "direct_b");
    tick();
    ifb.sel = 3'd3;
    push_b(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "direct_b");
    tick();
    ifb.ce_n = 1'b1;
    ifb.sel  = 3'd0;

    // Scan from 5 with wrap, paused after third word, ignored inputs mid-scan.
    ifa.din   = 32'h7654_3210;
    ifa.sel   = 3'd5;
    ifa.mode  = 1'b1;
    ifa.start = 1'b1;
    ifa.ce_n  = 1'b0;
    push_a(4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "accept");
    tick();
    words_a   = 0;
    ifa.start = 1'b0;
    ifa.sel   = 3'd0;
    for (int i = 0; i < 3; i++) begin
      push_a(scan5[i], 1'b1, scan5[i][2:0], 1'b1, 1'b1, 1'b0, "scan_wrap");
      tick();
    end
    ifa.ce_n = 1'b1;
    ifa.din  = 32'h89AB_CDEF;
    for (int i = 0; i < 3; i++) begin
      ifa.start = 1'b1;
      ifa.mode  = logic'(i % 2);
      push_a(4'd7, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, "pause");
      tick();
    end
    ifa.ce_n = 1'b0;
    for (int i = 3; i < 8; i++) begin
      ifa.start = 1'b1;
      ifa.mode  = logic'(i % 2);
      ifa.sel   = 3'd1;
      push_a(scan5[i], 1'b1, scan5[i][2:0], 1'b1, 1'b1, logic'(i == 7), "scan_wrap");
      tick();
    end

    // Start with mode=0 in IDLE: plain direct select of din 0x89ABCDEF.
    ifa.start = 1'b1;
    ifa.mode  = 1'b0;
    ifa.sel   = 3'd3;
    push_a(4'hC, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, "mode0_start");
    tick();
    checks++;
    if (words_a != 8) begin
      errors++;
      $display("FAIL scan_word_count: got %0d valid words, want 8", words_a);
    end
    ifa.sel = 3'd4;
    push_a(4'hB, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, "mode0_start");
    tick();

    // Reset after four words of a scan from 2.
    ifa.din   = 32'h7654_3210;
    ifa.sel   = 3'd2;
    ifa.mode  = 1'b1;
    ifa.start = 1'b1;
    ifa.ce_n  = 1'b0;
    push_a(4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "accept");
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_a(scan2[i], 1'b1, scan2[i][2:0], 1'b1, 1'b1, 1'b0, "scan_pre_reset");
      tick();
    end
    reset = 1'b1;
    push_a(4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "reset_mid");
    tick();
    reset    = 1'b0;
    ifa.mode = 1'b0;
    ifa.ce_n = 1'b1;
    ifa.sel  = 3'd6;
    for (int i = 0; i < 3; i++) begin
      push_a(4'h0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, "post_reset");
      tick();
    end

    // Full rescan from 2 after the abort.
    ifa.sel   = 3'd2;
    ifa.mode  = 1'b1;
    ifa.start = 1'b1;
    ifa.ce_n  = 1'b0;
    push_a(4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "accept");
    tick();
    words_a   = 0;
    ifa.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_a(scan2[i], 1'b1, scan2[i][2:0], 1'b1, 1'b1, logic'(i == 7), "rescan");
      tick();
    end
    ifa.mode = 1'b0;
    ifa.ce_n = 1'b1;
    ifa.sel  = 3'd0;
    push_a(4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "idle_after_scan");
    tick();
    checks++;
    if (words_a != 8) begin
      errors++;
      $display("FAIL rescan_word_count: got %0d valid words, want 8", words_a);
    end

    // Six-channel scan from 4: non-power-of-two wrap 4,5,0,1,2,3.
    ifb.din   = 6'b10_0110;
    ifb.sel   = 3'd4;
    ifb.mode  = 1'b1;
    ifb.start = 1'b1;
    ifb.ce_n  = 1'b0;
    push_b(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "accept_b");
    tick();
    ifb.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_b(scanb_q[i], 1'b1, scanb_ch[i], 1'b1, 1'b1, logic'(i == 5), "scan_b");
      tick();
    end
    ifb.mode = 1'b0;
    ifb.ce_n = 1'b1;
    ifb.sel  = 3'd0;
    push_b(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "idle_after_scan_b");
    tick();

    // Let the monitor drain, then confirm nothing was left unchecked.
    tick();
    tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
